decode_top: RTL and testbench
=============================

DECODE_TOP -- requirements
Module: decode_top

Interface
REQ-001 SHALL have parameter DEPTH, default 4: code buffer entries (power of 2, 2..16).
REQ-002 SHALL have parameter HOLD_TICKS, default 4: tick pulses each note stays lit (1..255).
REQ-003 SHALL have parameter GAP_TICKS, default 1: tick pulses of all-dark between notes (0..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port code_in  input  3  lane code: 000 rest, 001..101 lanes 0..4, 110/111 invalid.
REQ-007 SHALL have port code_valid  input  1  code_in is offered this cycle.
REQ-008 SHALL have port code_ready  output  1  block accepts code_in this cycle.
REQ-009 SHALL have port tick  input  1  one-cycle beat strobe from the tempo source.
REQ-010 SHALL have port lanes_out  output  5  one-hot (or zero) lane drive; bit i lights lane i.
REQ-011 SHALL have port busy  output  1  high while buffer non-empty or FSM not IDLE.
REQ-012 SHALL have port err  output  1  one-cycle pulse when an invalid code is accepted.

Function
REQ-013 SHALL accept a code on a rising edge where code_valid and code_ready are both high.
REQ-014 SHALL drive code_ready = not full and not reset; code_ready SHALL depend only on registered state and reset.
REQ-015 SHALL discard accepted codes 110/111 (no buffer entry) and pulse err high the cycle after acceptance.
REQ-016 SHALL store valid codes (000..101) in a FIFO of DEPTH entries, order preserved; pointers wrap modulo DEPTH.
REQ-017 SHALL decode: 000->00000, 001->00001, 010->00010, 011->00100, 100->01000, 101->10000.
REQ-018 SHALL implement FSM states IDLE, HOLD, GAP; lanes_out registered.
REQ-019 IDLE: when FIFO non-empty, SHALL pop head, load decoded value into lanes_out, clear tick counter, go HOLD on the same edge.
REQ-020 HOLD: SHALL count tick pulses only while state is HOLD; on the edge where tick is high and count = HOLD_TICKS-1, SHALL zero lanes_out and go GAP (or IDLE if GAP_TICKS = 0).
REQ-021 GAP: lanes_out SHALL be 00000; on the edge where tick is high and count = GAP_TICKS-1, SHALL go IDLE.
REQ-022 A code accepted at edge k into an empty FIFO with FSM IDLE SHALL appear on lanes_out after edge k+1.
REQ-023 A tick coinciding with the IDLE->HOLD edge SHALL NOT be counted.
REQ-024 Simultaneous push and pop SHALL be supported when non-full; occupancy unchanged.
REQ-025 Rest code 000 SHALL occupy a full HOLD and GAP period with lanes_out dark.
REQ-026 lanes_out SHALL never have more than one bit set.

Reset
REQ-027 On a rising edge with reset high SHALL: empty FIFO, state IDLE, counter 0, lanes_out 00000, err 0, busy 0.
REQ-028 Reset mid-HOLD or mid-GAP SHALL abort the note; lanes_out dark after that edge; buffered codes lost.
REQ-029 code_ready SHALL be 0 while reset is high and 1 in the first cycle after reset deasserts.

Structure
REQ-030 Shared package decode_pkg SHALL hold lane width 5, code width 3, code constants (REST, LANE0..LANE4), state enum, and the code->one-hot decode function.
REQ-031 FIFO SHALL be a sub-module code_fifo (parameter DEPTH; push, pop, data, full, empty).
REQ-032 decode_top SHALL contain FSM, tick counter (8 bits), decode and err logic only.

Verification
REQ-033 Reset, then code 011 with valid one cycle, tick every 10 cycles -> lanes_out 00100 from edge k+1 for 4 ticks, 00000 for 1 tick, busy low after.
REQ-034 Push 001,010,011,100,101 back-to-back with no ticks (DEPTH 4) -> code_ready low after 4th buffered (first popped), order 00001,00010,00100,01000,10000 preserved.
REQ-035 Push 110 then 111 -> err pulses once per code, FIFO stays empty, lanes_out stays 00000.
REQ-036 Push 000 then 101 -> 4+1 ticks dark, then lanes_out 10000.
REQ-037 Reset asserted mid-HOLD with 3 codes buffered -> lanes_out 00000, busy 0, code_ready 0 during reset, 1 the cycle after release.
REQ-038 GAP_TICKS=0, push 001 then 010 -> lanes_out goes 00001 to 00000 (IDLE cycle) to 00010; tick on load edge not counted.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared widths, lane codes, FSM states and the lane-code decoder
// used by the lane decoder and its code buffer.
package decode_pkg;
    localparam int LANE_W = 5;
    localparam int CODE_W = 3;

    localparam logic [CODE_W-1:0] REST  = 3'b000;
    localparam logic [CODE_W-1:0] LANE0 = 3'b001;
    localparam logic [CODE_W-1:0] LANE1 = 3'b010;
    localparam logic [CODE_W-1:0] LANE2 = 3'b011;
    localparam logic [CODE_W-1:0] LANE3 = 3'b100;
    localparam logic [CODE_W-1:0] LANE4 = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_GAP
    } state_t;

    function automatic logic [LANE_W-1:0] decode_code(input logic [CODE_W-1:0] c);
        logic [LANE_W-1:0] v;
        case (c)
            LANE0:   v = 5'b00001;
            LANE1:   v = 5'b00010;
            LANE2:   v = 5'b00100;
            LANE3:   v = 5'b01000;
            LANE4:   v = 5'b10000;
            default: v = 5'b00000;
        endcase
        return v;
    endfunction

    function automatic logic is_valid_code(input logic [CODE_W-1:0] c);
        return (c <= LANE4);
    endfunction
endpackage

// File: rtl/decode_top_fifo.sv
// Code buffer: DEPTH-entry FIFO of lane codes with wrapping pointers
// and an occupancy counter that drives full/empty.
module code_fifo
    import decode_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [CODE_W-1:0] din,
    output logic [CODE_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [CODE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign full   = (r_count == FULL_CNT);
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push && !reset) r_mem[r_wptr] <= din;
    end

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/decode_top.sv
// Lane decoder: buffers lane codes and plays each one as a lit lane for
// HOLD_TICKS beats followed by GAP_TICKS dark beats.
module decode_top
    import decode_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int HOLD_TICKS = 4,
    parameter int GAP_TICKS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic              tick,
    output logic [LANE_W-1:0] lanes_out,
    output logic              busy,
    output logic              err
);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_TICKS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_nxt;
    logic [LANE_W-1:0] r_lanes;
    logic [LANE_W-1:0] w_lanes_nxt;
    logic              r_err;
    logic              w_full;
    logic              w_empty;
    logic [CODE_W-1:0] w_head;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;

    assign code_ready = !w_full && !reset;
    assign w_accept   = code_valid && code_ready;
    assign w_push     = w_accept && is_valid_code(code_in);
    assign lanes_out  = r_lanes;
    assign busy       = !w_empty || (r_state != S_IDLE);
    assign err        = r_err;

    code_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (code_in),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // The counter only advances on ticks seen in HOLD/GAP, so a tick on the
    // load edge is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lanes_nxt = r_lanes;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_lanes_nxt = decode_code(w_head);
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (tick) begin
                    if (r_cnt == HOLD_LAST) begin
                        w_lanes_nxt = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            S_GAP: begin
                w_lanes_nxt = '0;
                if (tick) begin
                    if (r_cnt == GAP_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_lanes_nxt = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_lanes <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lanes <= w_lanes_nxt;
            r_err   <= w_accept && !is_valid_code(code_in);
        end
    end
endmodule

// File: tb/tb_decode_top.sv
// Bench for decode_top: code table sweep, scoreboard on lit-lane order,
// and hand-built timing sequences incl. a GAP_TICKS=0 instance.
module tb_decode_top;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] code_in = 3'b000;
    logic       code_valid = 1'b0;
    logic       code_ready;
    logic       tick = 1'b0;
    logic [4:0] lanes_out;
    logic       busy;
    logic       err;

    logic [2:0] c0 = 3'b000;
    logic       v0 = 1'b0;
    logic       t0 = 1'b0;
    logic       r0;
    logic [4:0] l0;
    logic       b0;
    logic       e0;

    int nvec = 0;
    int nerr = 0;
    int gcyc = 0;
    logic tick_on = 1'b0;
    logic [4:0] exp_q[$];
    logic [4:0] prev_lanes = 5'b0;

    typedef struct {
        logic [2:0] code;
        logic [4:0] lanes;
        logic       err;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    decode_top #(.DEPTH(4), .HOLD_TICKS(4), .GAP_TICKS(1)) u_dut (
        .clk(clk), .reset(reset), .code_in(code_in), .code_valid(code_valid),
        .code_ready(code_ready), .tick(tick), .lanes_out(lanes_out),
        .busy(busy), .err(err)
    );

    decode_top #(.DEPTH(4), .HOLD_TICKS(4), .GAP_TICKS(0)) u_dut0 (
        .clk(clk), .reset(reset), .code_in(c0), .code_valid(v0),
        .code_ready(r0), .tick(t0), .lanes_out(l0),
        .busy(b0), .err(e0)
    );

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] lane_model(input logic [2:0] c);
        if (c >= 3'd1 && c <= 3'd5) return 5'b00001 << (c - 3'd1);
        return 5'b00000;
    endfunction

    // Scoreboard: every rising lit lane must be the next expected note.
    always @(negedge clk) begin
        if (lanes_out != prev_lanes && lanes_out != 5'b0) begin
            if (exp_q.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL sb_unexpected: got %b expected none", lanes_out);
            end else begin
                check("sb_order", {3'b0, lanes_out}, {3'b0, exp_q.pop_front()});
            end
            check("onehot", 8'($countones(lanes_out) <= 1), 8'd1);
        end
        prev_lanes = lanes_out;
    end

    task automatic mstep(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        gcyc++;
        tick = 1'b0;
    endtask

    task automatic pstep();
        mstep(tick_on && (gcyc % 10 == 9));
    endtask

    task automatic send(input logic [2:0] c);
        code_in = c;
        code_valid = 1'b1;
        if (code_ready && lane_model(c) != 5'b0) exp_q.push_back(lane_model(c));
        pstep();
        code_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("ready_in_reset", {7'b0, code_ready}, 8'd0);
        mstep(1'b0);
        exp_q.delete();
        check("rst_lanes", {3'b0, lanes_out}, 8'd0);
        check("rst_busy", {7'b0, busy}, 8'd0);
        check("rst_err", {7'b0, err}, 8'd0);
        check("rst_ready", {7'b0, code_ready}, 8'd0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", {7'b0, code_ready}, 8'd1);
    endtask

    task automatic wait_idle(input string nm);
        tick_on = 1'b1;
        for (int i = 0; i < 600 && busy; i++) pstep();
        check(nm, {7'b0, busy}, 8'd0);
    endtask

    task automatic measure(output int h, output int g);
        logic t;
        h = 0; g = 0;
        for (int i = 0; i < 500 && lanes_out != 5'b0; i++) begin
            t = (gcyc % 10 == 9);
            mstep(t);
            if (t) h++;
        end
        for (int i = 0; i < 500 && busy; i++) begin
            t = (gcyc % 10 == 9);
            mstep(t);
            if (t) g++;
        end
    endtask

    initial begin
        int h, g, acc, nt;
        tbl[0] = '{3'b000, 5'b00000, 1'b0};
        tbl[1] = '{3'b001, 5'b00001, 1'b0};
        tbl[2] = '{3'b010, 5'b00010, 1'b0};
        tbl[3] = '{3'b011, 5'b00100, 1'b0};
        tbl[4] = '{3'b100, 5'b01000, 1'b0};
        tbl[5] = '{3'b101, 5'b10000, 1'b0};
        tbl[6] = '{3'b110, 5'b00000, 1'b1};
        tbl[7] = '{3'b111, 5'b00000, 1'b1};

        repeat (2) mstep(1'b0);
        do_reset();

        // Single 011 note, tick on load edge must not count.
        send(3'b011);
        check("t1_not_yet", {3'b0, lanes_out}, 8'd0);
        check("t1_busy", {7'b0, busy}, 8'd1);
        mstep(1'b1);
        check("t1_lit", {3'b0, lanes_out}, 8'b00100);
        measure(h, g);
        check("t1_hold_ticks", 8'(h), 8'd4);
        check("t1_gap_ticks", 8'(g), 8'd1);
        check("t1_busy_after", {7'b0, busy}, 8'd0);

        // Table sweep over all eight codes.
        for (int i = 0; i < 8; i++) begin
            tick_on = 1'b0;
            send(tbl[i].code);
            check($sformatf("tbl%0d_err", i), {7'b0, err}, {7'b0, tbl[i].err});
            pstep();
            check($sformatf("tbl%0d_lanes", i), {3'b0, lanes_out}, {3'b0, tbl[i].lanes});
            check($sformatf("tbl%0d_err_clr", i), {7'b0, err}, 8'd0);
            wait_idle($sformatf("tbl%0d_idle", i));
        end

        // Five back-to-back pushes, no ticks: fills after the fifth.
        tick_on = 1'b0;
        acc = 0;
        for (int i = 1; i <= 5; i++) begin
            if (code_ready) acc++;
            send(3'(i));
        end
        check("t2_accepted", 8'(acc), 8'd5);
        check("t2_full_ready", {7'b0, code_ready}, 8'd0);
        check("t2_first_lit", {3'b0, lanes_out}, 8'b00001);
        wait_idle("t2_drain");
        check("t2_sb_empty", 8'(exp_q.size()), 8'd0);

        // Invalid codes back-to-back.
        tick_on = 1'b0;
        send(3'b110);
        check("t3_err_a", {7'b0, err}, 8'd1);
        send(3'b111);
        check("t3_err_b", {7'b0, err}, 8'd1);
        pstep();
        check("t3_err_low", {7'b0, err}, 8'd0);
        check("t3_busy", {7'b0, busy}, 8'd0);
        check("t3_lanes", {3'b0, lanes_out}, 8'd0);

        // Rest then lane 4: 4+1 dark ticks before 10000.
        send(3'b000);
        send(3'b101);
        nt = 0;
        for (int i = 0; i < 500 && lanes_out == 5'b0; i++) begin
            logic t;
            t = (gcyc % 10 == 9);
            mstep(t);
            if (t) nt++;
        end
        check("t4_dark_ticks", 8'(nt), 8'd5);
        check("t4_lit", {3'b0, lanes_out}, 8'b10000);
        wait_idle("t4_drain");

        // Reset mid-HOLD with three codes buffered.
        tick_on = 1'b0;
        for (int i = 1; i <= 4; i++) send(3'(i));
        check("t5_lit", {3'b0, lanes_out}, 8'b00001);
        mstep(1'b1);
        do_reset();
        tick_on = 1'b1;
        for (int i = 0; i < 60; i++) pstep();
        check("t5_stay_dark", {3'b0, lanes_out}, 8'd0);
        check("t5_stay_idle", {7'b0, busy}, 8'd0);

        // GAP_TICKS=0 instance: lit -> one dark IDLE cycle -> next lit.
        tick_on = 1'b0;
        c0 = 3'b001; v0 = 1'b1;
        mstep(1'b0);
        c0 = 3'b010; t0 = 1'b1;
        mstep(1'b0);
        v0 = 1'b0; t0 = 1'b0;
        check("t6_lit1", {3'b0, l0}, 8'b00001);
        nt = 0;
        for (int i = 0; i < 500 && l0 == 5'b00001; i++) begin
            t0 = (gcyc % 10 == 9);
            if (t0) nt++;
            mstep(1'b0);
            t0 = 1'b0;
        end
        check("t6_hold_ticks", 8'(nt), 8'd4);
        check("t6_idle_dark", {3'b0, l0}, 8'd0);
        mstep(1'b0);
        check("t6_lit2", {3'b0, l0}, 8'b00010);
        for (int i = 0; i < 600 && b0; i++) begin
            t0 = (gcyc % 10 == 9);
            mstep(1'b0);
            t0 = 1'b0;
        end
        check("t6_idle", {7'b0, b0}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
